// File: rtl/multdiv_unit.sv
// Iterative signed multiplier/divider for the execute stage: radix-2 shift-add multiply and
// restoring divide on operand magnitudes, with the sign and the exception applied at completion.
module multdiv_unit #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned COUNT_WIDTH = 6
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] data_operandA,
  input  logic [DATA_WIDTH-1:0] data_operandB,
  input  logic                  ctrl_MULT,
  input  logic                  ctrl_DIV,
  output logic [DATA_WIDTH-1:0] data_result,
  output logic                  data_exception,
  output logic                  multdiv_is_running,
  output logic                  multdiv_result_ready
);

  localparam int unsigned PROD_WIDTH = 2 * DATA_WIDTH;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [COUNT_WIDTH-1:0] LAST_COUNT = COUNT_WIDTH'(DATA_WIDTH - 1);

  logic [1:0]             state;
  logic [1:0]             state_next;
  logic [COUNT_WIDTH-1:0] count;
  logic                   op_div;
  logic                   neg;
  logic                   div_zero;
  logic [DATA_WIDTH-1:0]  mag;
  logic [DATA_WIDTH-1:0]  hi;
  logic [DATA_WIDTH-1:0]  lo;

  logic                   start_c;
  logic                   last_c;
  logic [DATA_WIDTH-1:0]  mag_a_c;
  logic [DATA_WIDTH-1:0]  mag_b_c;
  logic [DATA_WIDTH:0]    mul_sum_c;
  logic [DATA_WIDTH-1:0]  mul_hi_c;
  logic [DATA_WIDTH-1:0]  mul_lo_c;
  logic [DATA_WIDTH:0]    div_shift_c;
  logic                   div_ge_c;
  logic [DATA_WIDTH-1:0]  div_hi_c;
  logic [DATA_WIDTH-1:0]  div_lo_c;
  logic [DATA_WIDTH-1:0]  hi_next_c;
  logic [DATA_WIDTH-1:0]  lo_next_c;
  logic [PROD_WIDTH-1:0]  prod_c;
  logic [PROD_WIDTH-1:0]  prod_s_c;
  logic [DATA_WIDTH:0]    prod_top_c;
  logic [DATA_WIDTH-1:0]  quot_s_c;
  logic [DATA_WIDTH-1:0]  result_c;
  logic                   exception_c;

  assign start_c = ctrl_MULT | ctrl_DIV;
  assign last_c  = (state == RUN) && (count == LAST_COUNT);
  assign mag_a_c = data_operandA[DATA_WIDTH-1] ? -data_operandA : data_operandA;
  assign mag_b_c = data_operandB[DATA_WIDTH-1] ? -data_operandB : data_operandB;

  // Next-state logic; starts are only honoured outside RUN
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = start_c ? RUN : IDLE;
      RUN:     state_next = last_c ? DONE : RUN;
      DONE:    state_next = start_c ? RUN : IDLE;
      default: state_next = start_c ? RUN : IDLE;
    endcase
  end

  // One iteration step plus the signed result of the completing iteration
  always_comb begin
    mul_sum_c   = {1'b0, hi} + (lo[0] ? {1'b0, mag} : '0);
    mul_hi_c    = mul_sum_c[DATA_WIDTH:1];
    mul_lo_c    = {mul_sum_c[0], lo[DATA_WIDTH-1:1]};

    div_shift_c = {hi, lo[DATA_WIDTH-1]};
    div_ge_c    = div_shift_c >= {1'b0, mag};
    div_hi_c    = div_ge_c ? DATA_WIDTH'(div_shift_c - {1'b0, mag})
                           : DATA_WIDTH'(div_shift_c);
    div_lo_c    = {lo[DATA_WIDTH-2:0], div_ge_c};

    hi_next_c   = op_div ? div_hi_c : mul_hi_c;
    lo_next_c   = op_div ? div_lo_c : mul_lo_c;

    prod_c      = {mul_hi_c, mul_lo_c};
    prod_s_c    = neg ? -prod_c : prod_c;
    prod_top_c  = prod_s_c[PROD_WIDTH-1:DATA_WIDTH-1];
    quot_s_c    = neg ? -div_lo_c : div_lo_c;

    result_c    = prod_s_c[DATA_WIDTH-1:0];
    exception_c = !((&prod_top_c) || !(|prod_top_c));
    if (op_div) begin
      if (div_zero) begin
        result_c    = '0;
        exception_c = 1'b1;
      end else begin
        // Only most-negative / -1 yields a positive quotient magnitude of 2^(W-1)
        result_c    = quot_s_c;
        exception_c = !neg && div_lo_c[DATA_WIDTH-1];
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Operand capture, iteration and registered outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count                <= '0;
      op_div               <= 1'b0;
      neg                  <= 1'b0;
      div_zero             <= 1'b0;
      mag                  <= '0;
      hi                   <= '0;
      lo                   <= '0;
      data_result          <= '0;
      data_exception       <= 1'b0;
      multdiv_is_running   <= 1'b0;
      multdiv_result_ready <= 1'b0;
    end else if (state == RUN) begin
      count <= count + COUNT_WIDTH'(1);
      hi    <= hi_next_c;
      lo    <= lo_next_c;
      if (last_c) begin
        data_result          <= result_c;
        data_exception       <= exception_c;
        multdiv_is_running   <= 1'b0;
        multdiv_result_ready <= 1'b1;
      end
    end else begin
      multdiv_result_ready <= 1'b0;
      if (start_c) begin
        count              <= '0;
        op_div             <= !ctrl_MULT;
        neg                <= data_operandA[DATA_WIDTH-1] ^ data_operandB[DATA_WIDTH-1];
        hi                 <= '0;
        multdiv_is_running <= 1'b1;
        if (ctrl_MULT) begin
          mag      <= mag_a_c;
          lo       <= mag_b_c;
          div_zero <= 1'b0;
        end else begin
          mag      <= mag_b_c;
          lo       <= mag_a_c;
          div_zero <= (data_operandB == '0);
        end
      end
    end
  end

endmodule

// File: tb/tb_multdiv_unit.sv
// Bench for multdiv_unit: directed cases plus randomized operations, each checked against a
// plain-arithmetic reference for value, exception, latency and handshake timing.
module tb_multdiv_unit;

  localparam int unsigned DW = 32;

  logic          clock;
  logic          reset_n;
  logic [DW-1:0] data_operandA;
  logic [DW-1:0] data_operandB;
  logic          ctrl_MULT;
  logic          ctrl_DIV;
  logic [DW-1:0] data_result;
  logic          data_exception;
  logic          multdiv_is_running;
  logic          multdiv_result_ready;

  int            total = 0;
  int            bad = 0;
  logic [DW-1:0] prev_res;

  multdiv_unit #(.DATA_WIDTH(32), .COUNT_WIDTH(6)) dut (
    .clock               (clock),
    .reset_n             (reset_n),
    .data_operandA       (data_operandA),
    .data_operandB       (data_operandB),
    .ctrl_MULT           (ctrl_MULT),
    .ctrl_DIV            (ctrl_DIV),
    .data_result         (data_result),
    .data_exception      (data_exception),
    .multdiv_is_running  (multdiv_is_running),
    .multdiv_result_ready(multdiv_result_ready)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // {exception, result} from signed arithmetic on the operands
  function automatic logic [32:0] model(input logic mul, input logic [31:0] a, input logic [31:0] b);
    longint p;
    int     q;
    if (mul) begin
      p = longint'($signed(a)) * longint'($signed(b));
      return {(p > 64'sd2147483647) || (p < -64'sd2147483648), p[31:0]};
    end
    if (b == 32'h0) return {1'b1, 32'h0};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b1, 32'h8000_0000};
    q = $signed(a) / $signed(b);
    return {1'b0, q};
  endfunction

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h7FFF_FFFF;
      4:       return 32'h1;
      5:       return 32'($urandom_range(0, 40)) - 32'd20;
      6:       return 32'($urandom_range(0, 32'h0001_FFFF));
      default: return $urandom;
    endcase
  endfunction

  // Called at a negedge; starts an op, optionally pulses ctrl_DIV at negedge 'inject' mid-run
  task automatic run_op(input logic mul, input logic dv, input logic [31:0] a, input logic [31:0] b,
                        input int inject, input logic chain, input string tag);
    logic [32:0] exp;
    int          k;
    int          run_cnt;
    exp = model(mul, a, b);
    data_operandA = a;
    data_operandB = b;
    ctrl_MULT = mul;
    ctrl_DIV = dv;
    @(negedge clock);
    ctrl_MULT = 1'b0;
    ctrl_DIV = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
    check({tag, "/busy"}, 32'(multdiv_is_running), 32'd1);
    check({tag, "/hold"}, data_result, prev_res);
    k = 1;
    run_cnt = 0;
    while (!multdiv_result_ready && k < 40) begin
      if (multdiv_is_running) run_cnt++;
      @(negedge clock);
      k++;
      ctrl_DIV = (k == inject);
    end
    ctrl_DIV = 1'b0;
    check({tag, "/ready"}, 32'(multdiv_result_ready), 32'd1);
    check({tag, "/latency"}, 32'(k), 32'd33);
    check({tag, "/busy_cycles"}, 32'(run_cnt), 32'd32);
    check({tag, "/result"}, data_result, exp[31:0]);
    check({tag, "/exception"}, 32'(data_exception), 32'(exp[32]));
    prev_res = exp[31:0];
    if (!chain) begin
      @(negedge clock);
      check({tag, "/ready_drop"}, 32'(multdiv_result_ready), 32'd0);
      check({tag, "/idle"}, 32'(multdiv_is_running), 32'd0);
    end
  endtask

  initial begin
    int pulses;
    int busy;
    logic mul;
    logic dv;
    clock = 1'b0;
    reset_n = 1'b1;
    ctrl_MULT = 1'b0;
    ctrl_DIV = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    prev_res = '0;
    #2 reset_n = 1'b0;
    #11;
    check("reset/result", data_result, 32'h0);
    check("reset/exception", 32'(data_exception), 32'd0);
    check("reset/busy", 32'(multdiv_is_running), 32'd0);
    check("reset/ready", 32'(multdiv_result_ready), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    run_op(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, 0, 1'b0, "mul_7x-3");
    run_op(1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000, 0, 1'b0, "mul_ovf_2p32");
    run_op(1'b1, 1'b0, 32'h7FFF_FFFF, 32'd2, 0, 1'b0, "mul_ovf_max2");
    run_op(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 0, 1'b0, "div_-7/2");
    run_op(1'b0, 1'b1, 32'd100, 32'hFFFF_FFF9, 0, 1'b0, "div_100/-7");
    run_op(1'b0, 1'b1, 32'd5, 32'd0, 0, 1'b0, "div_by_zero");
    run_op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0, "div_min/-1");
    run_op(1'b1, 1'b0, 32'd3, 32'd4, 6, 1'b0, "mul_ignore_div");
    run_op(1'b1, 1'b1, 32'd6, 32'd3, 0, 1'b0, "both_req");
    run_op(1'b1, 1'b0, 32'd0, 32'hFFFF_FFFB, 0, 1'b1, "mul_zero_chain");
    run_op(1'b0, 1'b1, 32'hFFFF_FFEC, 32'd3, 0, 1'b0, "div_from_done");

    // Abort a multiply mid-run with an asynchronous reset
    data_operandA = 32'd9;
    data_operandB = 32'd9;
    ctrl_MULT = 1'b1;
    @(negedge clock);
    ctrl_MULT = 1'b0;
    repeat (10) @(negedge clock);
    reset_n = 1'b0;
    #1;
    check("abort/result", data_result, 32'h0);
    check("abort/exception", 32'(data_exception), 32'd0);
    check("abort/busy", 32'(multdiv_is_running), 32'd0);
    check("abort/ready", 32'(multdiv_result_ready), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    pulses = 0;
    busy = 0;
    repeat (40) begin
      @(negedge clock);
      if (multdiv_result_ready) pulses++;
      if (multdiv_is_running) busy++;
    end
    check("abort/no_ready", 32'(pulses), 32'd0);
    check("abort/stays_idle", 32'(busy), 32'd0);
    prev_res = '0;
    run_op(1'b1, 1'b0, 32'd2, 32'd2, 0, 1'b0, "mul_after_abort");

    for (int i = 0; i < 24; i++) begin
      mul = 1'($urandom_range(0, 1));
      dv = !mul || 1'($urandom_range(0, 1));
      run_op(mul, dv, pick_val(), pick_val(),
             ($urandom_range(0, 1) != 0) ? int'($urandom_range(2, 32)) : 0,
             (i != 23) && ($urandom_range(0, 1) != 0), "random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
